pwm_breath_sequencer: RTL and testbench

Duty-cycle scheduler for the LED PWM generator. It ramps the PWM duty up, holds it, ramps it down, holds it, and repeats, producing a "breathing" LED effect. Duty changes are applied only on PWM period boundaries (period_tick from the PWM counter wrap), so the output never glitches mid-period. The block drives the duty and load-strobe inputs of the PWM datapath and reports its sequencing state.

---
 rtl/pwm_breath_sequencer.sv | 135 +++++++++++++
 tb/tb_pwm_breath_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pwm_breath_sequencer.sv
// Breathing-LED duty scheduler: ramps the PWM duty up, holds it, ramps it down,
// holds it, and repeats. Duty updates land only on PWM period boundaries.
module pwm_breath_sequencer #(
  parameter int unsigned PWM_PERIOD   = 20000,
  parameter int unsigned STEP         = 200,
  parameter int unsigned HOLD_PERIODS = 625,
  parameter int unsigned DUTY_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              period_tick,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [2:0]        state,
  output logic              cycle_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_HOLD_HIGH = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD_LOW  = 3'd4;

  localparam int unsigned CNT_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_PERIODS - 1);
  localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W:0]   PERIOD_X   = (DUTY_W + 1)'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] PERIOD_D   = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] STEP_D     = DUTY_W'(STEP);

  logic [2:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DUTY_W:0]   sum_up;

  // Next-state logic; enable drop outranks a coincident period tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    // One extra bit so duty + STEP can never wrap.
    sum_up  = {1'b0, duty_q} + STEP_X;

    case (state_q)
      S_IDLE: begin
        duty_d = '0;
        cnt_d  = '0;
        if (enable) state_d = S_RAMP_UP;
      end
      S_RAMP_UP, S_HOLD_HIGH, S_RAMP_DOWN, S_HOLD_LOW: begin
        if (!enable) begin
          state_d = S_IDLE;
          duty_d  = '0;
          cnt_d   = '0;
          valid_d = (duty_q != '0);
        end else if (period_tick) begin
          case (state_q)
            S_RAMP_UP: begin
              valid_d = 1'b1;
              if (sum_up >= PERIOD_X) begin
                duty_d  = PERIOD_D;
                state_d = S_HOLD_HIGH;
                cnt_d   = '0;
              end else begin
                duty_d = sum_up[DUTY_W-1:0];
              end
            end
            S_HOLD_HIGH: begin
              if (cnt_q == HOLD_LAST) begin
                state_d = S_RAMP_DOWN;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_RAMP_DOWN: begin
              valid_d = 1'b1;
              if ({1'b0, duty_q} <= STEP_X) begin
                duty_d  = '0;
                state_d = S_HOLD_LOW;
                cnt_d   = '0;
              end else begin
                duty_d = duty_q - STEP_D;
              end
            end
            S_HOLD_LOW: begin
              if (cnt_q == HOLD_LAST) begin
                state_d = S_RAMP_UP;
                cnt_d   = '0;
                done_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        duty_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = valid_q;
  assign state      = state_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Scoreboard bench for pwm_breath_sequencer with a small period/step/hold.
module tb_pwm_breath_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        period_tick = 1'b0;
  logic [15:0] duty;
  logic        duty_valid;
  logic [2:0]  state;
  logic        cycle_done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] du;
    logic        v;
    logic        d;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  pwm_breath_sequencer #(
    .PWM_PERIOD  (10),
    .STEP        (3),
    .HOLD_PERIODS(2),
    .DUTY_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period_tick(period_tick),
    .duty       (duty),
    .duty_valid (duty_valid),
    .state      (state),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic t,
                     input logic [2:0] s, input logic [15:0] du,
                     input logic v, input logic d, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    enable = e;
    period_tick = t;
    x.st = s; x.du = du; x.v = v; x.d = d; x.nm = nm;
    exp_q.push_back(x);
  endtask

  // One PWM period: a tick cycle followed by nine quiet cycles with steady outputs.
  task automatic period(input logic e, input logic [2:0] s, input logic [15:0] du,
                        input logic v, input logic d, input string nm);
    cyc(1'b0, e, 1'b1, s, du, v, d, nm);
    repeat (9) cyc(1'b0, e, 1'b0, s, du, 1'b0, 1'b0, {nm, "_quiet"});
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (state !== x.st || duty !== x.du || duty_valid !== x.v || cycle_done !== x.d) begin
          errors++;
          $display("FAIL %s: got state=%0d duty=%0d valid=%b done=%b, want state=%0d duty=%0d valid=%b done=%b",
                   x.nm, state, duty, duty_valid, cycle_done, x.st, x.du, x.v, x.d);
        end
      end
    end
  end

  initial begin
    // Reset with enable and ticks present.
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 16'd0, 1'b0, 1'b0, "idle_to_up");

    // Ramp up.
    period(1'b1, 3'd1, 16'd3,  1'b1, 1'b0, "up3");
    period(1'b1, 3'd1, 16'd6,  1'b1, 1'b0, "up6");
    period(1'b1, 3'd1, 16'd9,  1'b1, 1'b0, "up9");
    period(1'b1, 3'd2, 16'd10, 1'b1, 1'b0, "up_sat10");

    // Hold high, then ramp down.
    period(1'b1, 3'd2, 16'd10, 1'b0, 1'b0, "hold_hi1");
    period(1'b1, 3'd3, 16'd10, 1'b0, 1'b0, "hold_hi2");
    period(1'b1, 3'd3, 16'd7,  1'b1, 1'b0, "dn7");
    period(1'b1, 3'd3, 16'd4,  1'b1, 1'b0, "dn4");
    period(1'b1, 3'd3, 16'd1,  1'b1, 1'b0, "dn1");
    period(1'b1, 3'd4, 16'd0,  1'b1, 1'b0, "dn_floor0");

    // Hold low and cycle wrap.
    period(1'b1, 3'd4, 16'd0, 1'b0, 1'b0, "hold_lo1");
    period(1'b1, 3'd1, 16'd0, 1'b0, 1'b1, "cycle_done");
    period(1'b1, 3'd1, 16'd3, 1'b1, 1'b0, "wrap_up3");
    period(1'b1, 3'd1, 16'd6, 1'b1, 1'b0, "wrap_up6");

    // Enable drop together with a tick at duty=6.
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1, 1'b0, "en_drop");
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, "en_drop_after");
    period(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, "idle_tick1");
    period(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, "idle_tick2");

    // Back-to-back ticks from zero.
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 16'd0,  1'b0, 1'b0, "b2b_start");
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 16'd3,  1'b1, 1'b0, "b2b3");
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 16'd6,  1'b1, 1'b0, "b2b6");
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 16'd9,  1'b1, 1'b0, "b2b9");
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 16'd10, 1'b1, 1'b0, "b2b10");
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 16'd10, 1'b0, 1'b0, "b2b_hold1");
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 16'd10, 1'b0, 1'b0, "b2b_hold2");
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 16'd10, 1'b0, 1'b0, "b2b_quiet");

    // Reset mid-sequence, then enable drop with duty already zero.
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, "mid_reset");
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 16'd0, 1'b0, 1'b0, "restart");
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, "drop_at_zero");
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, "final_idle");

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
